// File: rtl/pll_lock_sequencer_if.sv
// PLL sequencer signal bundle: PLL lock/restart inputs, PLL reset, system reset and status.
// LOCK_LOSS_CNT_EN adds the lock_loss_cnt status field.
interface pll_lock_sequencer_if #(
  parameter int unsigned MaxRetries = 3
);
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  logic              pll_locked;
  logic              restart;
  logic              pll_rst;
  logic              ready;
  logic              sys_rst_n;
  logic              fail;
  logic [RetryW-1:0] retry_cnt;
  logic [2:0]        state_dbg;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0]        lock_loss_cnt;
`endif

  modport master (
    input  pll_locked, restart,
    output pll_rst, ready, sys_rst_n, fail, retry_cnt, state_dbg
`ifdef LOCK_LOSS_CNT_EN
    , output lock_loss_cnt
`endif
  );

  modport slave (
    output pll_locked, restart,
    input  pll_rst, ready, sys_rst_n, fail, retry_cnt, state_dbg
`ifdef LOCK_LOSS_CNT_EN
    , input lock_loss_cnt
`endif
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: timed PLL reset, qualified lock, retries, downstream reset.
// Optional LOCK_LOSS_CNT_EN adds a saturating count of RUN lock-loss events.
module pll_lock_sequencer #(
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned LockTimeout  = 50000,
  parameter int unsigned StableCycles = 1024,
  parameter int unsigned MaxRetries   = 3,
  parameter int unsigned CntW         = 16
) (
  input  logic                   refclk_i,
  input  logic                   rst_ni,
  pll_lock_sequencer_if.master   bus
);
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  localparam logic [CntW-1:0]   RstLast     = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LockTimeout - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(StableCycles - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MaxRetries);

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  state_e              state_q;
  logic [1:0]          sync_q;
  logic [CntW-1:0]     timer_q;
  logic [CntW-1:0]     timer_inc;
  logic [RetryW-1:0]   retry_q;
  logic                pll_rst_q;
  logic                ready_q;
  logic                fail_q;
  logic                lock_s;
  logic                lock_loss_evt;

  assign lock_s        = sync_q[1];
  assign timer_inc     = (timer_q == '1) ? timer_q : timer_q + CntW'(1);
  // restart outranks lock loss, so a coincident restart is not counted as a loss
  assign lock_loss_evt = (state_q == StRun) && !lock_s && !bus.restart;

  always_ff @(posedge refclk_i) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      state_q   <= StResetPll;
      timer_q   <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked};
      if (bus.restart) begin
        state_q   <= StResetPll;
        timer_q   <= '0;
        retry_q   <= '0;
        pll_rst_q <= 1'b1;
        ready_q   <= 1'b0;
        fail_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StResetPll: begin
            if (timer_q == RstLast) begin
              state_q   <= StWaitLock;
              timer_q   <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              timer_q <= timer_inc;
            end
          end
          StWaitLock: begin
            if (lock_s) begin
              state_q <= StStable;
              timer_q <= '0;
            end else if (timer_q == TimeoutLast) begin
              timer_q   <= '0;
              pll_rst_q <= 1'b1;
              if (retry_q == RetryMax) begin
                state_q <= StFail;
                fail_q  <= 1'b1;
              end else begin
                state_q <= StResetPll;
                retry_q <= retry_q + RetryW'(1);
              end
            end else begin
              timer_q <= timer_inc;
            end
          end
          StStable: begin
            if (!lock_s) begin
              state_q <= StWaitLock;
              timer_q <= '0;
            end else if (timer_q == StableLast) begin
              state_q <= StRun;
              timer_q <= '0;
              ready_q <= 1'b1;
            end else begin
              timer_q <= timer_inc;
            end
          end
          StRun: begin
            if (!lock_s) begin
              state_q   <= StResetPll;
              timer_q   <= '0;
              retry_q   <= '0;
              pll_rst_q <= 1'b1;
              ready_q   <= 1'b0;
            end
          end
          StFail: begin
          end
          default: begin
            state_q   <= StResetPll;
            timer_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lossc_q;

  always_ff @(posedge refclk_i) begin
    if (!rst_ni) begin
      lossc_q <= '0;
    end else if (lock_loss_evt && (lossc_q != 8'hff)) begin
      lossc_q <= lossc_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = lossc_q;
`else
  logic unused_lock_loss_evt;
  assign unused_lock_loss_evt = lock_loss_evt;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.ready     = ready_q;
  assign bus.sys_rst_n = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_dbg = 3'(state_q);
endmodule
